// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the CPU interrupt-side peripherals.
package cpu_pkg;
    localparam int WDT_WIDTH = 32;
    localparam logic [1:0] WDT_IDLE    = 2'd0;
    localparam logic [1:0] WDT_COUNT   = 2'd1;
    localparam logic [1:0] WDT_FIRE    = 2'd2;
    localparam logic [1:0] WDT_SERVICE = 2'd3;
endpackage

// File: rtl/wdt_down_counter.sv
// wdt_down_counter: loadable down counter that stops at zero and pulses expire on the 1->0 step.
module wdt_down_counter
    import cpu_pkg::*;
#(
    parameter int WIDTH = WDT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reload,
    input  logic [WIDTH-1:0] reload_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             expire
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = reload ? reload_val : (dec && count_q != '0) ? count_q - 1'b1 : count_q;
        expire  = dec && count_q == WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/watchdog_timer.sv
// watchdog_timer: quantum timer driving irq1 with ack/clr handshake and sticky overrun.
module watchdog_timer
    import cpu_pkg::*;
#(
    parameter int               WIDTH         = WDT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_QUANTUM = 32'd1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ack,
    input  logic             clr,
    output logic             irq,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             overrun
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] quantum_q, quantum_d;
    logic             irq_q, irq_d, busy_q, busy_d, overrun_q, overrun_d;
    logic             reload, dec, expire;

    wdt_down_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .reload    (reload),
        .reload_val(quantum_d),
        .dec       (dec),
        .count     (count),
        .expire    (expire)
    );

    // reloads use quantum_d so a load in the same cycle takes effect immediately
    always_comb begin
        quantum_d = load ? ((load_data == '0) ? WIDTH'(1) : load_data) : quantum_q;
        state_d   = state_q;
        irq_d     = irq_q;
        busy_d    = busy_q;
        overrun_d = load ? 1'b0 : overrun_q;
        reload    = 1'b0;
        dec       = 1'b0;
        if (!enable) begin
            state_d = WDT_IDLE;
            irq_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                WDT_IDLE: begin
                    reload  = 1'b1;
                    state_d = WDT_COUNT;
                end
                WDT_COUNT: begin
                    dec = 1'b1;
                    if (expire) begin
                        irq_d   = 1'b1;
                        state_d = WDT_FIRE;
                    end
                end
                WDT_FIRE: begin
                    if (ack) begin
                        irq_d   = 1'b0;
                        busy_d  = 1'b1;
                        reload  = 1'b1;
                        state_d = WDT_SERVICE;
                    end
                end
                default: begin
                    dec = 1'b1;
                    if (clr) begin
                        busy_d  = 1'b0;
                        reload  = 1'b1;
                        state_d = WDT_COUNT;
                    end else if (expire) begin
                        overrun_d = 1'b1;
                        reload    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= WDT_IDLE;
            quantum_q <= RESET_QUANTUM;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            quantum_q <= quantum_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end

    assign irq     = irq_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_watchdog_timer.sv
// tb_watchdog_timer: table-driven cycle vectors plus async-reset sequence for watchdog_timer.
module tb_watchdog_timer;
    typedef struct {
        logic        en, ld;
        logic [31:0] ld_data;
        logic        ack, clr, e_irq;
        logic [31:0] e_cnt;
        logic        e_busy, e_ov;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0, ack = 1'b0, clr = 1'b0;
    logic [31:0] load_data = '0;
    logic        irq, busy, overrun;
    logic [31:0] count;
    int          total = 0, bad = 0;
    vec_t        vecs[$];

    watchdog_timer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .load     (load),
        .load_data(load_data),
        .ack      (ack),
        .clr      (clr),
        .irq      (irq),
        .count    (count),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic void add(logic en, logic ld, logic [31:0] d, logic a, logic c,
                                logic ei, logic [31:0] ec, logic eb, logic eo);
        vec_t v;
        v.en = en; v.ld = ld; v.ld_data = d; v.ack = a; v.clr = c;
        v.e_irq = ei; v.e_cnt = ec; v.e_busy = eb; v.e_ov = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset and quantum 5 countdown
        add(0, 1, 5, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 5, 0, 0);
        for (int c = 4; c >= 1; c--) add(1, 0, 0, 0, 0, 0, c, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // FIRE held without ack; clr alone ignored
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, i % 2, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 5, 1, 0);
        add(1, 0, 0, 0, 0, 0, 4, 1, 0);
        add(1, 0, 0, 1, 0, 0, 3, 1, 0);
        add(1, 0, 0, 0, 0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 1, 0, 5, 0, 0);
        for (int c = 4; c >= 1; c--) add(1, 0, 0, 0, 0, 0, c, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // overrun in SERVICE, then load clears it
        add(1, 0, 0, 1, 0, 0, 5, 1, 0);
        for (int c = 4; c >= 1; c--) add(1, 0, 0, 0, 0, 0, c, 1, 0);
        add(1, 0, 0, 0, 0, 0, 5, 1, 1);
        add(1, 1, 8, 0, 0, 0, 4, 1, 0);
        add(1, 0, 0, 0, 1, 0, 8, 0, 0);
        for (int c = 7; c >= 1; c--) add(1, 0, 0, 0, 0, 0, c, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // ack+clr together, then disable mid-count
        add(1, 0, 0, 1, 1, 0, 8, 1, 0);
        add(1, 0, 0, 0, 1, 0, 8, 0, 0);
        for (int c = 7; c >= 3; c--) add(1, 0, 0, 0, 0, 0, c, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 0, 0);
        add(0, 0, 0, 1, 1, 0, 3, 0, 0);
        // zero load becomes quantum 1; disable beats ack in FIRE
        add(0, 1, 0, 0, 0, 0, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);

        #12;
        check("rst_irq", -1, 32'(irq), 0);
        check("rst_count", -1, count, 0);
        check("rst_busy", -1, 32'(busy), 0);
        check("rst_overrun", -1, 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            enable = vecs[i].en; load = vecs[i].ld; load_data = vecs[i].ld_data;
            ack = vecs[i].ack; clr = vecs[i].clr;
            @(posedge clk);
            #1;
            check("irq", i, 32'(irq), 32'(vecs[i].e_irq));
            check("count", i, count, vecs[i].e_cnt);
            check("busy", i, 32'(busy), 32'(vecs[i].e_busy));
            check("overrun", i, 32'(overrun), 32'(vecs[i].e_ov));
        end

        // asynchronous reset while in FIRE
        @(negedge clk);
        enable = 1'b1; load = 1'b0; ack = 1'b0; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_irq", -2, 32'(irq), 0);
        check("async_count", -2, count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_quantum", -3, count, 1000);
        @(posedge clk);
        #1;
        check("reset_quantum_dec", -3, count, 999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
